// File: rtl/shift_ctrl.sv
// Parallel-to-serial shift controller with hold/pause and registered outputs.
// Optional even-parity trailer bit is compiled in with SHIFT_CTRL_PARITY_EN.
module shift_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic             dir,
    input  logic             hold,
    output logic             ready,
    output logic             s_out,
    output logic             s_valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH) + 1;

`ifdef SHIFT_CTRL_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd3} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             s_out_q, s_out_d;
    logic             s_valid_q, s_valid_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SHIFT_CTRL_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             cur_bit;
    logic [WIDTH-1:0] shifted;

    // The bit currently on s_out always sits at the outgoing end of sreg_q.
    assign cur_bit = dir_q ? sreg_q[WIDTH-1] : sreg_q[0];
    assign shifted = dir_q ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        s_out_d   = s_out_q;
        s_valid_d = 1'b0;
`ifdef SHIFT_CTRL_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SHIFT;
                    sreg_d    = din;
                    dir_d     = dir;
                    cnt_d     = '0;
                    s_out_d   = dir ? din[WIDTH-1] : din[0];
                    s_valid_d = 1'b1;
`ifdef SHIFT_CTRL_PARITY_EN
                    par_d     = 1'b0;
`endif
                end
            end
            SHIFT: begin
                // hold freezes everything; s_out keeps the pending bit.
                if (!hold) begin
                    sreg_d = shifted;
                    cnt_d  = cnt_q + CW'(1);
`ifdef SHIFT_CTRL_PARITY_EN
                    par_d  = par_q ^ cur_bit;
`endif
                    if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SHIFT_CTRL_PARITY_EN
                        state_d   = PARITY;
                        s_out_d   = par_q ^ cur_bit;
                        s_valid_d = 1'b1;
`else
                        state_d   = DONE;
`endif
                    end else begin
                        s_out_d   = dir_q ? shifted[WIDTH-1] : shifted[0];
                        s_valid_d = 1'b1;
                    end
                end
            end
`ifdef SHIFT_CTRL_PARITY_EN
            PARITY:  state_d = DONE;
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            s_out_q   <= 1'b0;
            s_valid_q <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SHIFT_CTRL_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            s_out_q   <= s_out_d;
            s_valid_q <= s_valid_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SHIFT_CTRL_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign ready     = ready_q;
    assign s_out     = s_out_q;
    assign s_valid   = s_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_shift_ctrl.sv
// Directed bench for shift_ctrl (WIDTH=8); expectations follow SHIFT_CTRL_PARITY_EN if defined.
module tb_shift_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] din = '0;
    logic         dir = 1'b0;
    logic         hold = 1'b0;
    logic         ready, s_out, s_valid, busy, done;
    logic [1:0]   state_dbg;

    int errors = 0;
    int checks = 0;

    shift_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .din(din), .dir(dir), .hold(hold),
        .ready(ready), .s_out(s_out), .s_valid(s_valid), .busy(busy), .done(done),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // exp_seq lists the serial bits in transmission order, first bit in the MSB.
    task automatic run_word(input string name, input logic [W-1:0] w, input logic d,
                            input logic [W-1:0] exp_seq, input logic exp_par,
                            input int hold_after, input int hold_len, input bit inject);
        logic eb;
        din = w; dir = d; start = 1'b1;
        step();
        start = 1'b0;
        din = ~w; dir = ~d;
        for (int i = 0; i < W; i++) begin
            eb = exp_seq[W-1-i];
            checks++;
            if (s_valid !== 1'b1 || s_out !== eb || ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s bit%0d: s_valid=%b s_out=%b ready=%b busy=%b done=%b, expected 1 %b 0 1 0",
                         name, i, s_valid, s_out, ready, busy, done, eb);
            end
            if (inject && i == 2) begin
                start = 1'b1;
                din = '1;
            end
            if (i + 1 == hold_after) begin
                hold = 1'b1;
                for (int j = 0; j < hold_len; j++) begin
                    step();
                    checks++;
                    if (s_valid !== 1'b0 || s_out !== eb || busy !== 1'b1 || done !== 1'b0) begin
                        errors++;
                        $display("FAIL %s hold%0d: s_valid=%b s_out=%b busy=%b done=%b, expected 0 %b 1 0",
                                 name, j, s_valid, s_out, busy, done, eb);
                    end
                end
                hold = 1'b0;
            end
            step();
            start = 1'b0;
        end
`ifdef SHIFT_CTRL_PARITY_EN
        checks++;
        if (s_valid !== 1'b1 || s_out !== exp_par || done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s parity: s_valid=%b s_out=%b done=%b busy=%b, expected 1 %b 0 1",
                     name, s_valid, s_out, done, busy, exp_par);
        end
        hold = 1'b1;
        step();
        hold = 1'b0;
`else
        if (exp_par !== 1'b0 && exp_par !== 1'b1) $display("note: %s parity reference undefined", name);
`endif
        checks++;
        if (done !== 1'b1 || s_valid !== 1'b0 || busy !== 1'b1 || ready !== 1'b0) begin
            errors++;
            $display("FAIL %s done: done=%b s_valid=%b busy=%b ready=%b, expected 1 0 1 0",
                     name, done, s_valid, busy, ready);
        end
        step();
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || s_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: ready=%b done=%b busy=%b s_valid=%b, expected 1 0 0 0",
                     name, ready, done, busy, s_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || s_valid !== 1'b0 || done !== 1'b0 ||
            s_out !== 1'b0 || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL reset: ready=%b busy=%b s_valid=%b done=%b s_out=%b state=%0d, expected 1 0 0 0 0 0",
                     ready, busy, s_valid, done, s_out, state_dbg);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_lsb_first();
        run_word("lsb_a5", 8'hA5, 1'b0, 8'b10100101, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_msb_first();
        run_word("msb_81", 8'h81, 1'b1, 8'b10000001, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_hold();
        run_word("hold_a5", 8'hA5, 1'b0, 8'b10100101, 1'b0, 3, 3, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_word("inject_a5", 8'hA5, 1'b0, 8'b10100101, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic test_abort();
        logic [W-1:0] seq;
        logic saw_done;
        seq = 8'b10100101;
        din = 8'hA5; dir = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (s_valid !== 1'b1 || s_out !== seq[W-1-i]) begin
                errors++;
                $display("FAIL abort bit%0d: s_valid=%b s_out=%b, expected 1 %b", i, s_valid, s_out, seq[W-1-i]);
            end
            step();
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || s_valid !== 1'b0 || done !== 1'b0 || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL abort reset: ready=%b busy=%b s_valid=%b done=%b state=%0d, expected 1 0 0 0 0",
                     ready, busy, s_valid, done, state_dbg);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL abort quiet: activity seen after abort, expected done=0 busy=0");
        end
        run_word("after_abort_3c", 8'h3C, 1'b0, 8'b00111100, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_word("b2b_81", 8'h81, 1'b1, 8'b10000001, 1'b0, 0, 0, 1'b0);
        run_word("b2b_07", 8'h07, 1'b0, 8'b11100000, 1'b1, 0, 0, 1'b0);
        run_word("b2b_07_msb", 8'h07, 1'b1, 8'b00000111, 1'b1, 0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_hold();
        test_start_ignored();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_ctrl.md
SHIFT_CTRL -- requirements
Module: shift_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the shift word length in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port start  input  1  request to load din and begin shifting.
REQ-005 SHALL have port din  input  WIDTH  parallel word to serialize.
REQ-006 SHALL have port dir  input  1  shift order: 0 = right shift (LSB first), 1 = left shift (MSB first).
REQ-007 SHALL have port hold  input  1  pause request during shifting.
REQ-008 SHALL have port ready  output  1  high only in IDLE; start is accepted only when high.
REQ-009 SHALL have port s_out  output  1  serial data bit.
REQ-010 SHALL have port s_valid  output  1  s_out carries a valid bit this cycle.
REQ-011 SHALL have port busy  output  1  high in SHIFT, PARITY and DONE.
REQ-012 SHALL have port done  output  1  single-cycle completion pulse.

Function
REQ-013 SHALL implement states IDLE, SHIFT, PARITY (only if compiled in), DONE; all outputs registered.
REQ-014 In IDLE with start=1 on an edge: SHALL capture din into the shift register, capture dir, clear the bit counter, and enter SHIFT.
REQ-015 In SHIFT: SHALL drive s_out = LSB of the shift register (dir=0) or MSB (dir=1), with s_valid=1; first bit appears the cycle after start is accepted.
REQ-016 Each SHIFT cycle with hold=0: SHALL shift the register one position (right for dir=0, left for dir=1, zero fill) and increment the counter (width $clog2(WIDTH)+1).
REQ-017 With hold=1 in SHIFT: SHALL freeze the register and counter and drive s_valid=0; s_out holds its value; shifting resumes when hold returns to 0, with no bit lost or repeated.
REQ-018 After the WIDTH-th valid bit: SHALL go to PARITY if compiled in, else DONE.
REQ-019 DONE SHALL last exactly one cycle with done=1, s_valid=0, then return to IDLE.
REQ-020 start SHALL be ignored while not in IDLE; din and dir changes after capture SHALL not affect the word in flight.
REQ-021 hold SHALL be ignored outside SHIFT (including PARITY).
REQ-022 Minimum start-to-start spacing SHALL be WIDTH+2 cycles (WIDTH+3 with parity), hold cycles excluded.

Reset
REQ-023 On an edge with rst=0: state=IDLE, shift register=0, counter=0, captured dir=0, parity accumulator=0, ready=1, s_out=0, s_valid=0, busy=0, done=0.
REQ-024 Reset SHALL take priority over start and hold and SHALL abort any word in flight mid-operation; no done pulse is produced for the aborted word.

Configuration
REQ-025 Macro SHIFT_CTRL_PARITY_EN: when defined, the block SHALL accumulate the XOR of the WIDTH data bits and emit it in PARITY as one extra bit (s_out=even parity, s_valid=1, one cycle, hold ignored) before DONE.
REQ-026 When SHIFT_CTRL_PARITY_EN is not defined, the block SHALL contain no PARITY state or accumulator and go from the last data bit directly to DONE.

Verification
REQ-027 WIDTH=8, din=8'hA5, dir=0, start pulse at edge T -> s_out 1,0,1,0,0,1,0,1 with s_valid=1 in cycles T+1..T+8; done=1 at T+9 (parity build: s_out=0 at T+9, done at T+10); ready=1 from T+10 (T+11 with parity).
REQ-028 din=8'h81, dir=1 -> s_out 1,0,0,0,0,0,0,1 MSB first; parity build emits 0.
REQ-029 din=8'hA5, dir=0, hold=1 for 3 cycles after the 3rd bit -> s_valid=0 for those 3 cycles, remaining bits 0,0,1,0,1 follow unchanged; done 3 cycles later than REQ-027.
REQ-030 start=1 with din=8'hFF asserted during SHIFT of 8'hA5 -> ignored; serial stream still matches 8'hA5; ready stays 0 until IDLE.
REQ-031 rst=0 for one edge after 4th bit -> next cycle state IDLE, s_valid=0, busy=0, ready=1, no done pulse; a following start of 8'h3C serializes correctly (dir=0: 0,0,1,1,1,1,0,0).
REQ-032 din=8'h07 (3 ones) with SHIFT_CTRL_PARITY_EN defined -> parity bit s_out=1; same stimulus without the macro -> done directly after the 8th bit.
